// File: rtl/img_sector_server_if.sv
// Sector-transfer port (FDC side) and byte-wide memory port (arbiter side) of img_sector_server.
// Latency: none. This bundle holds wires only.
// Backpressure: the memory side stalls through mem_ready. The FDC side is never stalled.
//
// Signals:
//   sd_*  : sector request and sector-buffer access, seen from the responder
//   mem_* : byte memory request. mem_rd and mem_wr are held until the one-cycle mem_ready.
// The master modport is the responder. The slave modport is the FDC plus the memory arbiter.
interface img_sector_server_if #(
    parameter int MEM_AW = 27
) ();
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_din;
    logic              sd_din_strobe;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;
    logic              mem_ready;

    modport master (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, sd_din_strobe,
               mem_addr, mem_rd, mem_wr, mem_dout
    );

    modport slave (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, sd_din_strobe,
               mem_addr, mem_rd, mem_wr, mem_dout
    );
endinterface

// File: rtl/img_sector_server.sv
// Serves 512-byte floppy sector reads and writes from a disk image in byte-addressed memory.
// Latency: a read byte takes k+2 cycles (k = mem_ready delay). A write byte takes k+3 cycles, or 3 when skipped.
// Backpressure: each byte stalls on mem_ready. An out-of-range or write-protected sector never touches memory.
//
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   img_size     : image length in bytes (0 = no image)
//   img_wp       : write protect. The sector is still consumed, but nothing is written to memory.
//   bus          : sector-transfer port and memory port (img_sector_server_if.master)
module img_sector_server #(
    parameter int                MEM_AW    = 27,
    parameter logic [MEM_AW-1:0] BASE_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [31:0]               img_size,
    input  logic                      img_wp,
    img_sector_server_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_PUT,
        S_WR_ADDR,
        S_WR_GET,
        S_WR_MEM,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [31:0]       r_lba_q;
    logic              r_in_range;
    logic [8:0]        r_idx;
    logic              r_ack;
    logic [8:0]        r_buff_addr;
    logic [7:0]        r_buff_dout;
    logic              r_buff_wr;
    logic              r_din_strobe;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [7:0]        r_mem_dout;

    logic              w_req_in_range;
    logic              w_last;
    logic [8:0]        w_idx_nxt;

    // The sector's last byte must lie inside the image.
    // 41 bits holds {lba, 9'b0} + 511 without wrapping.
    assign w_req_in_range = (({bus.sd_lba, 9'b0} + 41'd511) < {9'b0, img_size});
    assign w_last         = (r_idx == 9'd511);
    assign w_idx_nxt      = r_idx + 9'd1;

    function automatic logic [MEM_AW-1:0] f_addr(input logic [31:0] lba, input logic [8:0] idx);
        return MEM_AW'(41'(BASE_ADDR) + {lba, idx});
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_lba_q      <= '0;
            r_in_range   <= 1'b0;
            r_idx        <= '0;
            r_ack        <= 1'b0;
            r_buff_addr  <= '0;
            r_buff_dout  <= '0;
            r_buff_wr    <= 1'b0;
            r_din_strobe <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_dout   <= '0;
        end else begin
            r_buff_wr    <= 1'b0;
            r_din_strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (bus.sd_rd) begin
                        r_lba_q    <= bus.sd_lba;
                        r_in_range <= w_req_in_range;
                        r_ack      <= 1'b1;
                        r_state    <= S_RD_REQ;
                        // Issue the first read on the RD_REQ entry edge.
                        // This keeps every read byte at k+2 cycles.
                        if (w_req_in_range) begin
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= f_addr(bus.sd_lba, 9'd0);
                        end
                    end else if (bus.sd_wr) begin
                        r_lba_q     <= bus.sd_lba;
                        r_in_range  <= w_req_in_range;
                        r_ack       <= 1'b1;
                        r_buff_addr <= '0;
                        r_state     <= S_WR_ADDR;
                    end
                end

                S_RD_REQ: begin
                    if (!r_in_range) begin
                        r_buff_addr <= r_idx;
                        r_buff_dout <= 8'h00;
                        r_buff_wr   <= 1'b1;
                        r_state     <= S_RD_PUT;
                    end else if (bus.mem_ready) begin
                        r_mem_rd    <= 1'b0;
                        r_buff_addr <= r_idx;
                        r_buff_dout <= bus.mem_din;
                        r_buff_wr   <= 1'b1;
                        r_state     <= S_RD_PUT;
                    end
                end

                S_RD_PUT: begin
                    if (w_last) begin
                        r_ack   <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= w_idx_nxt;
                        r_state <= S_RD_REQ;
                        if (r_in_range) begin
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= f_addr(r_lba_q, w_idx_nxt);
                        end
                    end
                end

                // sd_buff_addr was set on entry here.
                // The FDC presents the matching byte one cycle later, during WR_GET.
                S_WR_ADDR: begin
                    r_din_strobe <= 1'b1;
                    r_state      <= S_WR_GET;
                end

                S_WR_GET: begin
                    r_mem_dout <= bus.sd_buff_din;
                    r_state    <= S_WR_MEM;
                    if (r_in_range && !img_wp) begin
                        r_mem_wr   <= 1'b1;
                        r_mem_addr <= f_addr(r_lba_q, r_idx);
                    end
                end

                S_WR_MEM: begin
                    // A skipped write (mem_wr never raised) takes a single cycle here.
                    if (!r_mem_wr || bus.mem_ready) begin
                        r_mem_wr <= 1'b0;
                        if (w_last) begin
                            r_ack   <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx       <= w_idx_nxt;
                            r_buff_addr <= w_idx_nxt;
                            r_state     <= S_WR_ADDR;
                        end
                    end
                end

                // Requests are level-held.
                // Wait for both to drop so a finished request cannot re-trigger.
                S_DONE: begin
                    if (!bus.sd_rd && !bus.sd_wr) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sd_ack        = r_ack;
    assign bus.sd_buff_addr  = r_buff_addr;
    assign bus.sd_buff_dout  = r_buff_dout;
    assign bus.sd_buff_wr    = r_buff_wr;
    assign bus.sd_din_strobe = r_din_strobe;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_rd        = r_mem_rd;
    assign bus.mem_wr        = r_mem_wr;
    assign bus.mem_dout      = r_mem_dout;

endmodule
